// File: rtl/ysyx_23060072_regfile_sb_pkg.sv
// Shared RV32E definitions for the register file / scoreboard slice.
// XLEN, architectural register count, register-address width and the zero register.
package ysyx_23060072_regfile_sb_pkg;

    localparam int XLEN       = 32;
    localparam int RV32E_NREG = 16;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/ysyx_23060072_sb_counter.sv
// Per-register pending-write counter: saturates at its maximum and never underflows.
// A reservation and a release in the same cycle cancel out.
module ysyx_23060072_sb_counter #(
    parameter int PEND_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic last,
    output logic full
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && count != CNT_MAX) begin
            count <= count + CNT_ONE;
        end else if (dec && !inc && count != '0) begin
            count <= count - CNT_ONE;
        end
    end

    assign busy = (count != '0);
    assign last = (count == CNT_ONE);
    assign full = (count == CNT_MAX);

endmodule

// File: rtl/ysyx_23060072_regfile_sb.sv
// RV32E register file with write-through read bypass and a pending-write scoreboard
// that raises a read-after-write stall toward decode.
module ysyx_23060072_regfile_sb
    import ysyx_23060072_regfile_sb_pkg::*;
#(
    parameter int NREG   = RV32E_NREG,
    parameter int PEND_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_flag_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic                  rs1_used_i,
    input  logic                  rs2_used_i,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o,
    input  logic                  issue_i,
    input  logic                  rd_wen_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  raw_stall_o,
    output logic                  rd_full_o,
    output logic                  addr_err_o
);

    localparam int IDX_W = $clog2(NREG);

    xlen_t regs [NREG];

    logic [NREG-1:0] busy;
    logic [NREG-1:0] last;
    logic [NREG-1:0] full;

    logic [IDX_W-1:0] wb_idx, rs1_idx, rs2_idx, rd_idx;
    logic             wb_in, rs1_in, rs2_in, rd_in;
    logic             rd_full_int;
    logic             reserve;
    logic             release_wb;
    logic             addr_err_d;

    function automatic logic in_range(input reg_addr_t a);
        return int'(a) < NREG;
    endfunction

    function automatic xlen_t read_port(input reg_addr_t a, input logic [IDX_W-1:0] ai);
        if (rst || a == ZERO_REG || !in_range(a)) begin
            return '0;
        end
        if (wb_flag_i && wb_addr_i == a) begin
            return wb_data_i;
        end
        return regs[ai];
    endfunction

    // The writeback that retires the last reservation does not stall: its data is bypassed.
    function automatic logic src_stall(input logic used, input reg_addr_t a,
                                       input logic busy_a, input logic last_a);
        return used && a != ZERO_REG && in_range(a) && busy_a &&
               !(wb_flag_i && wb_addr_i == a && last_a);
    endfunction

    assign wb_idx  = wb_addr_i[IDX_W-1:0];
    assign rs1_idx = rs1_addr_i[IDX_W-1:0];
    assign rs2_idx = rs2_addr_i[IDX_W-1:0];
    assign rd_idx  = rd_addr_i[IDX_W-1:0];

    assign wb_in  = in_range(wb_addr_i);
    assign rs1_in = in_range(rs1_addr_i);
    assign rs2_in = in_range(rs2_addr_i);
    assign rd_in  = in_range(rd_addr_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else if (wb_flag_i && wb_addr_i != ZERO_REG && wb_in) begin
            regs[wb_idx] <= wb_data_i;
        end
    end

    always_comb begin
        rs1_data_o = read_port(rs1_addr_i, rs1_idx);
        rs2_data_o = read_port(rs2_addr_i, rs2_idx);
    end

    assign rd_full_int = rd_wen_i && rd_addr_i != ZERO_REG && rd_in && full[rd_idx];
    assign reserve     = issue_i && rd_wen_i && rd_addr_i != ZERO_REG && !rd_full_int;
    assign release_wb  = wb_flag_i && wb_addr_i != ZERO_REG;

    // x0 carries no counter and is never pending.
    assign busy[0] = 1'b0;
    assign last[0] = 1'b0;
    assign full[0] = 1'b0;

    for (genvar k = 1; k < NREG; k++) begin : g_cnt
        ysyx_23060072_sb_counter #(
            .PEND_W(PEND_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (reserve && rd_addr_i == reg_addr_t'(k)),
            .dec  (release_wb && wb_addr_i == reg_addr_t'(k)),
            .busy (busy[k]),
            .last (last[k]),
            .full (full[k])
        );
    end

    assign raw_stall_o = !rst &&
        (src_stall(rs1_used_i, rs1_addr_i, busy[rs1_idx], last[rs1_idx]) ||
         src_stall(rs2_used_i, rs2_addr_i, busy[rs2_idx], last[rs2_idx]));
    assign rd_full_o = !rst && rd_full_int;

    assign addr_err_d = (wb_flag_i  && !wb_in)  ||
                        (rs1_used_i && !rs1_in) ||
                        (rs2_used_i && !rs2_in) ||
                        (reserve    && !rd_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_o <= 1'b0;
        end else if (addr_err_d) begin
            addr_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_regfile_sb.sv
// Randomized and directed bench for the register file / scoreboard, checked against
// an array-and-counter reference model built from the behavioural rules.
module tb_ysyx_23060072_regfile_sb;

    localparam int NR       = 16;
    localparam int PEND_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_flag;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rs1_used, rs2_used, issue, rd_wen;
    logic [31:0] rs1_data, rs2_data;
    logic        raw_stall, rd_full, addr_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [NR];
    int          m_pend [NR];
    logic        m_err;

    ysyx_23060072_regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .wb_flag_i  (wb_flag),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_used_i (rs1_used),
        .rs2_used_i (rs2_used),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .issue_i    (issue),
        .rd_wen_i   (rd_wen),
        .rd_addr_i  (rd_addr),
        .raw_stall_o(raw_stall),
        .rd_full_o  (rd_full),
        .addr_err_o (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (rst || a == 0 || a >= NR) return 32'd0;
        if (wb_flag && wb_addr == a) return wb_data;
        return m_regs[a[3:0]];
    endfunction

    function automatic logic src_stall(input logic used, input logic [4:0] a);
        if (!used || a == 0 || a >= NR) return 1'b0;
        if (m_pend[a[3:0]] == 0) return 1'b0;
        if (wb_flag && wb_addr == a && m_pend[a[3:0]] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic full_now();
        return rd_wen && rd_addr != 0 && rd_addr < NR && m_pend[rd_addr[3:0]] == PEND_MAX;
    endfunction

    task automatic idle();
        rst = 0; wb_flag = 0; wb_addr = 0; wb_data = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
        issue = 0; rd_wen = 0; rd_addr = 0;
    endtask

    // Let combinational outputs settle mid-cycle and compare every output to the model.
    task automatic settle();
        #3;
        chk("rs1_data", rs1_data, exp_read(rs1_addr));
        chk("rs2_data", rs2_data, exp_read(rs2_addr));
        chk("raw_stall", {31'd0, raw_stall},
            {31'd0, !rst && (src_stall(rs1_used, rs1_addr) || src_stall(rs2_used, rs2_addr))});
        chk("rd_full", {31'd0, rd_full}, {31'd0, !rst && full_now()});
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    endtask

    task automatic advance();
        logic res, rel, inc, dec;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NR; r++) begin m_regs[r] = 0; m_pend[r] = 0; end
            m_err = 0;
        end else begin
            res = issue && rd_wen && rd_addr != 0 && !full_now();
            rel = wb_flag && wb_addr != 0;
            if (rel && wb_addr < NR) m_regs[wb_addr[3:0]] = wb_data;
            if ((wb_flag && wb_addr >= NR) || (rs1_used && rs1_addr >= NR) ||
                (rs2_used && rs2_addr >= NR) || (res && rd_addr >= NR)) m_err = 1;
            for (int r = 1; r < NR; r++) begin
                inc = res && rd_addr == 5'(r);
                dec = rel && wb_addr == 5'(r);
                if (inc && !dec && m_pend[r] < PEND_MAX) m_pend[r]++;
                else if (dec && !inc && m_pend[r] > 0) m_pend[r]--;
            end
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic do_issue(input logic [4:0] rd);
        idle(); issue = 1; rd_wen = 1; rd_addr = rd; cycle();
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
        idle(); wb_flag = 1; wb_addr = a; wb_data = d; cycle();
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 5'($urandom_range(16, 31));
        return 5'($urandom_range(0, 15));
    endfunction

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin m_regs[r] = 0; m_pend[r] = 0; end
        m_err = 0;

        // Reset held one cycle, then read every register.
        idle(); rst = 1; wb_flag = 1; wb_addr = 5; wb_data = 32'hFFFF_FFFF;
        rs1_used = 1; rs1_addr = 5; settle();
        chk("rst_rs1_zero", rs1_data, 32'd0);
        advance();
        for (int r = 1; r < NR; r++) begin
            idle(); rs1_addr = 5'(r); rs2_addr = 5'(NR - r); settle();
            chk("rst_read", rs1_data, 32'd0);
            advance();
        end
        chk("rst_err", {31'd0, addr_err}, 32'd0);

        // Write with same-cycle bypass, then hold; x0 ignores writes.
        idle(); wb_flag = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rs1_addr = 5; settle();
        chk("bypass", rs1_data, 32'hDEADBEEF);
        advance();
        idle(); rs1_addr = 5; settle();
        chk("wr_hold", rs1_data, 32'hDEADBEEF);
        advance();
        do_wb(0, 32'h1234);
        idle(); rs1_addr = 0; settle();
        chk("x0_zero", rs1_data, 32'd0);
        advance();

        // RAW stall on x3, released by its writeback.
        do_issue(3);
        idle(); rs2_used = 1; rs2_addr = 3; settle();
        chk("raw_x3", {31'd0, raw_stall}, 32'd1);
        advance();
        idle(); rs2_used = 1; rs2_addr = 3; wb_flag = 1; wb_addr = 3; wb_data = 32'h55; settle();
        chk("raw_x3_rel", {31'd0, raw_stall}, 32'd0);
        chk("raw_x3_data", rs2_data, 32'h55);
        advance();

        // Two writers on x7.
        do_issue(7); do_issue(7);
        idle(); rs1_used = 1; rs1_addr = 7; wb_flag = 1; wb_addr = 7; wb_data = 32'h7;
        settle(); chk("x7_first_wb", {31'd0, raw_stall}, 32'd1); advance();
        settle(); chk("x7_second_wb", {31'd0, raw_stall}, 32'd0); advance();

        // x9: simultaneous reserve+release, saturation, release at zero.
        do_issue(9);
        idle(); issue = 1; rd_wen = 1; rd_addr = 9; wb_flag = 1; wb_addr = 9; wb_data = 32'h9;
        cycle();
        idle(); rs1_used = 1; rs1_addr = 9; settle();
        chk("x9_still1", {31'd0, raw_stall}, 32'd1);
        wb_flag = 1; wb_addr = 9; wb_data = 32'h99; settle();
        chk("x9_last", {31'd0, raw_stall}, 32'd0);
        wb_flag = 0; advance();
        do_issue(9); do_issue(9);
        idle(); issue = 1; rd_wen = 1; rd_addr = 9; settle();
        chk("x9_full", {31'd0, rd_full}, 32'd1);
        advance();
        for (int i = 0; i < 4; i++) do_wb(9, 32'h900 + i);
        idle(); rs1_used = 1; rs1_addr = 9; settle();
        chk("x9_empty", {31'd0, raw_stall}, 32'd0);
        advance();
        do_issue(9);
        idle(); rs1_used = 1; rs1_addr = 9; wb_flag = 1; wb_addr = 9; wb_data = 32'h9A; cycle();

        // Out-of-range writeback, then reset with reservations outstanding.
        do_wb(20, 32'hBAD0BAD0);
        chk("bad_err", {31'd0, addr_err}, 32'd1);
        for (int r = 1; r < NR; r++) begin
            idle(); rs1_addr = 5'(r); cycle();
        end
        do_issue(4); do_issue(4);
        idle(); rst = 1; cycle();
        idle(); rs1_used = 1; rs1_addr = 4; settle();
        chk("rst_nostall", {31'd0, raw_stall}, 32'd0);
        chk("rst_err_clr", {31'd0, addr_err}, 32'd0);
        advance();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            wb_flag  = $urandom_range(0, 2) == 0;
            wb_addr  = rand_addr();
            wb_data  = $urandom;
            rs1_addr = rand_addr();
            rs2_addr = rand_addr();
            rs1_used = $urandom_range(0, 1) == 1;
            rs2_used = $urandom_range(0, 1) == 1;
            issue    = $urandom_range(0, 1) == 1;
            rd_wen   = $urandom_range(0, 3) != 0;
            rd_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 3)) : rand_addr();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
